vga_frame_scheduler: RTL

Frame/line sequencer between the camera-side pixel FIFO and the image-processing datapath feeding the VGA output. It owns the pixel read schedule: each displayed line pulls exactly `IMG_W` pixel slots from the FIFO at a fixed offset from the VGA line timing, so processed pixels land inside the centred display window. It also shadows the processing opcode so that filter changes take effect only on frame boundaries. It reports FIFO underflow instead of stalling, which keeps display timing deterministic.

---
 rtl/vga_sched_pkg.sv | 18 +
 rtl/sat_counter.sv | 28 ++
 rtl/vga_frame_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vga_sched_pkg.sv
// rtl/vga_sched_pkg.sv - shared types and constants for the VGA frame scheduler
package vga_sched_pkg;
    localparam int DEF_IMG_W  = 512;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_OPW    = 4;
    // Slot-to-pixel latency; the integrator subtracts this when placing i_line_start
    localparam int PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_BURST
    } sched_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - per-line FIFO read schedule with frame-stable opcode shadow
module vga_frame_scheduler
    import vga_sched_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int OPW   = DEF_OPW
) (
    input  logic           axi_clk,
    input  logic           axi_reset_n,
    input  logic           i_frame_start,
    input  logic           i_line_start,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_fifo_empty,
    input  logic [7:0]     i_fifo_data,
    output logic           o_fifo_rd_en,
    output logic           o_data_valid,
    output logic [7:0]     o_data,
    output logic [OPW-1:0] o_opcode,
    output logic           o_busy,
    output logic           o_frame_done,
    output logic           o_frame_underflow,
    output logic [15:0]    o_underflow_cnt
);
    localparam int SW = cnt_width(IMG_W);
    localparam int LW = cnt_width(IMG_H);
    localparam logic [SW-1:0] SLOT_LAST = SW'(IMG_W - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_H - 1);

    sched_state_e   state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [LW-1:0]  line_q, line_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic           frame_uf_q, frame_uf_d;
    logic           done_q;
    logic           s1_valid_q, s1_read_q;
    logic           s2_valid_q;
    logic [7:0]     s2_data_q;
    logic           in_burst, slot_underflow, last_slot, last_line;

    assign in_burst       = (state_q == ST_BURST);
    assign slot_underflow = in_burst && i_fifo_empty;
    assign last_slot      = in_burst && (slot_q == SLOT_LAST);
    assign last_line      = (line_q == LINE_LAST);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        line_d     = line_q;
        opcode_d   = opcode_q;
        frame_uf_d = frame_uf_q;
        if (slot_underflow) begin
            frame_uf_d = 1'b1;
        end
        case (state_q)
            ST_WAIT_LINE: begin
                if (i_line_start) begin
                    state_d = ST_BURST;
                    slot_d  = '0;
                end
            end
            ST_BURST: begin
                if (slot_q == SLOT_LAST) begin
                    if (last_line) begin
                        state_d = ST_IDLE;
                    end else begin
                        line_d  = line_q + 1'b1;
                        state_d = ST_WAIT_LINE;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A frame start resynchronises from any state and overrides the line schedule
        if (i_frame_start) begin
            state_d    = ST_WAIT_LINE;
            line_d     = '0;
            opcode_d   = i_opcode;
            frame_uf_d = 1'b0;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            line_q     <= '0;
            opcode_q   <= '0;
            frame_uf_q <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_read_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            line_q     <= line_d;
            opcode_q   <= opcode_d;
            frame_uf_q <= frame_uf_d;
            done_q     <= last_slot && last_line;
            s1_valid_q <= in_burst;
            s1_read_q  <= o_fifo_rd_en;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_read_q ? i_fifo_data : 8'h00;
        end
    end

    sat_counter #(.W(16)) u_underflow_cnt (
        .clk_i  (axi_clk),
        .rst_ni (axi_reset_n),
        .inc_i  (slot_underflow),
        .cnt_o  (o_underflow_cnt)
    );

    assign o_fifo_rd_en      = in_burst && !i_fifo_empty;
    assign o_data_valid      = s2_valid_q;
    assign o_data            = s2_data_q;
    assign o_opcode          = opcode_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_frame_done      = done_q;
    assign o_frame_underflow = frame_uf_q;
endmodule
